// File: rtl/store_retire_buffer_pkg.sv
// Shared bus types, store-buffer entry/state types and byte-range helpers for store_retire_buffer.
// The helpers are used only when SB_LOAD_FWD_EN is defined.
package store_retire_buffer_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        MEM_SIZE         size;
    } SB_ENTRY;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } SB_STATE;

    function automatic logic [3:0] size_bytes(input MEM_SIZE size);
        return 4'd1 << size;
    endfunction

    function automatic logic [XLEN-1:0] size_mask(input MEM_SIZE size);
        case (size)
            BYTE:    return {{(XLEN-8){1'b0}}, 8'hFF};
            HALF:    return {{(XLEN-16){1'b0}}, 16'hFFFF};
            default: return '1;
        endcase
    endfunction

    // Half-open byte ranges compared one bit wider so a range ending at the top of memory cannot wrap.
    function automatic logic bytes_overlap(input logic [XLEN-1:0] a_addr, input MEM_SIZE a_size,
                                           input logic [XLEN-1:0] b_addr, input MEM_SIZE b_size);
        logic [XLEN:0] a_lo, a_hi, b_lo, b_hi;
        a_lo = {1'b0, a_addr};
        b_lo = {1'b0, b_addr};
        a_hi = a_lo + {{(XLEN-3){1'b0}}, size_bytes(a_size)};
        b_hi = b_lo + {{(XLEN-3){1'b0}}, size_bytes(b_size)};
        return (a_lo < b_hi) && (b_lo < a_hi);
    endfunction

endpackage

// File: rtl/store_retire_buffer_sb_fwd_lookup.sv
// Store-to-load forwarding search over the valid store-buffer entries, youngest entry deciding.
// Present only when SB_LOAD_FWD_EN is defined.
`ifdef SB_LOAD_FWD_EN
module sb_fwd_lookup
    import store_retire_buffer_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int PW       = $clog2(SB_DEPTH),
    parameter int CW       = $clog2(SB_DEPTH + 1)
) (
    input  SB_ENTRY         entries_i [SB_DEPTH],
    input  logic [PW-1:0]   head_i,
    input  logic [CW-1:0]   count_i,
    input  logic [XLEN-1:0] ld_addr_i,
    input  MEM_SIZE         ld_size_i,
    output logic            fwd_hit_o,
    output logic            fwd_conflict_o,
    output logic [XLEN-1:0] fwd_data_o
);

    logic [PW-1:0] idx;
    SB_ENTRY       cand;

    // Walk oldest to youngest so the youngest overlapping entry decides the result.
    always_comb begin
        fwd_hit_o      = 1'b0;
        fwd_conflict_o = 1'b0;
        fwd_data_o     = '0;
        idx            = '0;
        cand           = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx  = head_i + PW'(k);
            cand = entries_i[idx];
            if ((CW'(k) < count_i) && bytes_overlap(cand.addr, cand.size, ld_addr_i, ld_size_i)) begin
                if (cand.addr == ld_addr_i && cand.size == ld_size_i) begin
                    fwd_hit_o      = 1'b1;
                    fwd_conflict_o = 1'b0;
                    fwd_data_o     = cand.data & size_mask(cand.size);
                end else begin
                    fwd_hit_o      = 1'b0;
                    fwd_conflict_o = 1'b1;
                    fwd_data_o     = '0;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/store_retire_buffer.sv
// Post-commit store queue draining retired stores to the Dmem port in program order, loads first.
// Defining SB_LOAD_FWD_EN adds the store-to-load forwarding ports and the sb_fwd_lookup search.
module store_retire_buffer
    import store_retire_buffer_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  BUS_COMMAND      ret_command,
    input  MEM_SIZE         ret_size,
    input  logic [XLEN-1:0] ret_addr,
    input  logic [XLEN-1:0] ret_data,
    input  logic            halt,
    input  logic            load_req,
    input  logic [3:0]      Dmem2proc_response,
    output BUS_COMMAND      proc2Dmem_command,
    output MEM_SIZE         proc2Dmem_size,
    output logic [XLEN-1:0] proc2Dmem_addr,
    output logic [XLEN-1:0] proc2Dmem_data,
    output logic            sb_full,
    output logic            sb_empty,
    output logic            drained,
    output logic            overflow
`ifdef SB_LOAD_FWD_EN
    ,
    input  logic [XLEN-1:0] ld_addr,
    input  MEM_SIZE         ld_size,
    output logic            fwd_hit,
    output logic            fwd_conflict,
    output logic [XLEN-1:0] fwd_data
`endif
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(SB_DEPTH);

    SB_ENTRY       entries_q [SB_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    SB_STATE       state_q, state_d;
    logic          sb_full_q, sb_empty_q, overflow_q;
    logic          store_wins, push, pop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        store_wins = !load_req || halt;
        push       = (ret_command == BUS_STORE) && !sb_full_q;
        pop        = (state_q == SB_REQ) && store_wins && (Dmem2proc_response != 4'h0);

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        state_d = state_q;
        if (state_q == SB_IDLE) begin
            if (count_q != '0 && store_wins) state_d = SB_REQ;
        end else begin
            // A load preempts the request; otherwise keep issuing while anything is left after this cycle.
            if (!store_wins || (pop && count_d == '0)) state_d = SB_IDLE;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SB_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            sb_full_q  <= 1'b0;
            sb_empty_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            sb_full_q  <= (count_d == FULL_COUNT);
            sb_empty_q <= (count_d == '0);
            overflow_q <= overflow_q || ((ret_command == BUS_STORE) && sb_full_q);
        end
    end

    // NOTE: entry storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            entries_q[tail_q] <= '{addr: ret_addr, data: ret_data, size: ret_size};
        end
    end

    assign proc2Dmem_command = ((state_q == SB_REQ) && store_wins) ? BUS_STORE : BUS_NONE;
    assign proc2Dmem_size    = entries_q[head_q].size;
    assign proc2Dmem_addr    = entries_q[head_q].addr;
    assign proc2Dmem_data    = entries_q[head_q].data;
    assign sb_full           = sb_full_q;
    assign sb_empty          = sb_empty_q;
    assign drained           = sb_empty_q && (state_q == SB_IDLE);
    assign overflow          = overflow_q;

`ifdef SB_LOAD_FWD_EN
    sb_fwd_lookup #(
        .SB_DEPTH (SB_DEPTH),
        .PW       (PW),
        .CW       (CW)
    ) u_fwd (
        .entries_i      (entries_q),
        .head_i         (head_q),
        .count_i        (count_q),
        .ld_addr_i      (ld_addr),
        .ld_size_i      (ld_size),
        .fwd_hit_o      (fwd_hit),
        .fwd_conflict_o (fwd_conflict),
        .fwd_data_o     (fwd_data)
    );
`endif

endmodule

// File: tb/tb_store_retire_buffer.sv
// Directed bench for store_retire_buffer: a queue-level model checked every cycle plus literal pins.
// Forwarding checks are compiled in when SB_LOAD_FWD_EN is defined.
module tb_store_retire_buffer;
    import store_retire_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic            clock = 1'b0;
    logic            reset;
    BUS_COMMAND      ret_command;
    MEM_SIZE         ret_size;
    logic [XLEN-1:0] ret_addr, ret_data;
    logic            halt, load_req;
    logic [3:0]      resp;
    BUS_COMMAND      proc2Dmem_command;
    MEM_SIZE         proc2Dmem_size;
    logic [XLEN-1:0] proc2Dmem_addr, proc2Dmem_data;
    logic            sb_full, sb_empty, drained, overflow;
`ifdef SB_LOAD_FWD_EN
    logic [XLEN-1:0] ld_addr;
    MEM_SIZE         ld_size;
    logic            fwd_hit, fwd_conflict;
    logic [XLEN-1:0] fwd_data;
`endif

    store_retire_buffer #(.SB_DEPTH(DEPTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .ret_command        (ret_command),
        .ret_size           (ret_size),
        .ret_addr           (ret_addr),
        .ret_data           (ret_data),
        .halt               (halt),
        .load_req           (load_req),
        .Dmem2proc_response (resp),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_size     (proc2Dmem_size),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .sb_full            (sb_full),
        .sb_empty           (sb_empty),
        .drained            (drained),
        .overflow           (overflow)
`ifdef SB_LOAD_FWD_EN
        ,
        .ld_addr            (ld_addr),
        .ld_size            (ld_size),
        .fwd_hit            (fwd_hit),
        .fwd_conflict       (fwd_conflict),
        .fwd_data           (fwd_data)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the queue of committed-but-unwritten stores and whether a store request is armed on the port.
    SB_ENTRY         m_q[$];
    bit              m_armed = 1'b0;
    bit              m_ovf   = 1'b0;
    bit              started = 1'b0;
    logic [XLEN-1:0] log_q[$];

    always @(posedge clock) begin : model
        int sz0;
        bit wins, acc;
        if (reset) begin
            m_q.delete();
            m_armed = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            sz0  = m_q.size();
            wins = !load_req || halt;
            acc  = m_armed && wins && (resp != 4'h0);
            if (acc) void'(m_q.pop_front());
            if (ret_command == BUS_STORE) begin
                if (sz0 == DEPTH) m_ovf = 1'b1;
                else m_q.push_back('{addr: ret_addr, data: ret_data, size: ret_size});
            end
            if (!m_armed) m_armed = (sz0 > 0) && wins;
            else if (!wins || (acc && m_q.size() == 0)) m_armed = 1'b0;
        end
        started = 1'b1;
    end

    always @(negedge clock) begin
        BUS_COMMAND e_cmd;
        if (started) begin
            e_cmd = (m_armed && (!load_req || halt)) ? BUS_STORE : BUS_NONE;
            check("cmd", proc2Dmem_command, e_cmd);
            if (e_cmd == BUS_STORE) begin
                check("head_addr", proc2Dmem_addr, m_q[0].addr);
                check("head_data", proc2Dmem_data, m_q[0].data);
                check("head_size", proc2Dmem_size, m_q[0].size);
            end
            check("sb_full", sb_full, m_q.size() == DEPTH);
            check("sb_empty", sb_empty, m_q.size() == 0);
            check("drained", drained, (m_q.size() == 0) && !m_armed);
            check("overflow", overflow, m_ovf);
            if (proc2Dmem_command == BUS_STORE && resp != 4'h0) log_q.push_back(proc2Dmem_addr);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic put_store(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input MEM_SIZE s);
        ret_command = BUS_STORE;
        ret_addr    = a;
        ret_data    = d;
        ret_size    = s;
    endtask

    task automatic no_store();
        ret_command = BUS_NONE;
    endtask

    initial begin
        reset       = 1'b1;
        ret_command = BUS_NONE;
        ret_size    = WORD;
        ret_addr    = '0;
        ret_data    = '0;
        halt        = 1'b0;
        load_req    = 1'b0;
        resp        = 4'h0;
`ifdef SB_LOAD_FWD_EN
        ld_addr     = '0;
        ld_size     = WORD;
`endif
        tick();
        tick();
        reset = 1'b0;
        at_neg();
        check("rst_cmd", proc2Dmem_command, BUS_NONE);
        check("rst_empty", sb_empty, 1'b1);
        check("rst_full", sb_full, 1'b0);
        check("rst_drained", drained, 1'b1);
        check("rst_overflow", overflow, 1'b0);

        // Single store: head request one cycle after the enqueue edge, drained after the accepted pop.
        tick(); put_store(32'h100, 32'hDEADBEEF, WORD); resp = 4'h1;
        tick(); no_store(); at_neg();
        check("single_wait_cmd", proc2Dmem_command, BUS_NONE);
        tick(); at_neg();
        check("single_cmd", proc2Dmem_command, BUS_STORE);
        check("single_addr", proc2Dmem_addr, 32'h100);
        check("single_data", proc2Dmem_data, 32'hDEADBEEF);
        check("single_busy", drained, 1'b0);
        tick(); at_neg();
        check("single_empty", sb_empty, 1'b1);
        check("single_drained", drained, 1'b1);

        // Fill with the port stalled, overflow on the fifth, then four pops on consecutive cycles.
        resp = 4'h0;
        for (int k = 0; k < 4; k++) begin
            tick(); put_store(32'h10 + 32'(4 * k), 32'hA0 + 32'(k), WORD);
        end
        tick(); put_store(32'h20, 32'hBAD, WORD); at_neg();
        check("fill_full", sb_full, 1'b1);
        check("fill_no_ovf_yet", overflow, 1'b0);
        tick(); no_store(); resp = 4'h1; at_neg();
        check("fill_overflow", overflow, 1'b1);
        check("fill_cmd0", proc2Dmem_command, BUS_STORE);
        check("fill_addr0", proc2Dmem_addr, 32'h10);
        for (int k = 1; k < 4; k++) begin
            tick(); at_neg();
            check("fill_cmd", proc2Dmem_command, BUS_STORE);
            check("fill_addr", proc2Dmem_addr, 32'h10 + 32'(4 * k));
            check("fill_data", proc2Dmem_data, 32'hA0 + 32'(k));
        end
        tick(); at_neg();
        check("fill_drained", drained, 1'b1);
        check("fill_dropped_not_issued", proc2Dmem_command, BUS_NONE);

        // Reset in the middle of a request discards the entry and clears overflow.
        tick(); resp = 4'h0; put_store(32'h40, 32'h4444, HALF);
        tick(); no_store();
        tick(); at_neg();
        check("rstmid_cmd", proc2Dmem_command, BUS_STORE);
        check("rstmid_addr", proc2Dmem_addr, 32'h40);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; resp = 4'h1; at_neg();
        check("rstmid_after_cmd", proc2Dmem_command, BUS_NONE);
        check("rstmid_after_drained", drained, 1'b1);
        check("rstmid_after_ovf", overflow, 1'b0);
        tick(); tick(); at_neg();
        check("rstmid_no_reissue", proc2Dmem_command, BUS_NONE);

        // Load priority: a pending request is preempted and resumes the cycle after load_req falls.
        tick(); resp = 4'h0; put_store(32'h60, 32'h6, WORD);
        tick(); put_store(32'h64, 32'h7, WORD);
        tick(); no_store(); at_neg();
        check("ld_retry_addr", proc2Dmem_addr, 32'h60);
        check("ld_retry_cmd", proc2Dmem_command, BUS_STORE);
        for (int k = 0; k < 3; k++) begin
            tick(); load_req = 1'b1; at_neg();
            check("ld_blocked_cmd", proc2Dmem_command, BUS_NONE);
        end
        tick(); load_req = 1'b0; resp = 4'h1; at_neg();
        check("ld_fall_cmd", proc2Dmem_command, BUS_NONE);
        tick(); at_neg();
        check("ld_resume_addr", proc2Dmem_addr, 32'h60);
        check("ld_resume_cmd", proc2Dmem_command, BUS_STORE);
        tick(); at_neg();
        check("ld_second_addr", proc2Dmem_addr, 32'h64);
        tick(); at_neg();
        check("ld_drained", drained, 1'b1);

        // Halt: stores win over a held load request; drained follows the second accepted pop.
        tick(); load_req = 1'b1; halt = 1'b1; resp = 4'h1; put_store(32'h500, 32'hC, BYTE);
        tick(); put_store(32'h504, 32'hD, BYTE);
        tick(); no_store(); at_neg();
        check("halt_cmd0", proc2Dmem_command, BUS_STORE);
        check("halt_addr0", proc2Dmem_addr, 32'h500);
        tick(); at_neg();
        check("halt_addr1", proc2Dmem_addr, 32'h504);
        check("halt_not_drained", drained, 1'b0);
        tick(); at_neg();
        check("halt_drained", drained, 1'b1);
        tick(); load_req = 1'b0; halt = 1'b0;

        // Wrap: ten stores with a push and a pop in the same cycles; order must survive the pointer wrap.
        log_q.delete();
        resp = 4'h1;
        for (int k = 0; k < 10; k++) begin
            tick(); put_store(32'h300 + 32'(4 * k), 32'(k) * 32'h01010101, WORD);
            if (k >= 3) begin
                at_neg();
                check("wrap_not_full", sb_full, 1'b0);
                check("wrap_not_empty", sb_empty, 1'b0);
            end
        end
        tick(); no_store();
        repeat (4) tick();
        at_neg();
        check("wrap_count", 64'(log_q.size()), 64'd10);
        for (int k = 0; k < 10 && k < log_q.size(); k++) begin
            check("wrap_order", log_q[k], 32'h300 + 32'(4 * k));
        end
        check("wrap_drained", drained, 1'b1);

`ifdef SB_LOAD_FWD_EN
        // Forwarding: partial overlap conflicts, exact youngest match forwards zero-extended data.
        tick(); load_req = 1'b1; resp = 4'h0; ld_addr = 32'h200; ld_size = WORD;
        put_store(32'h200, 32'h11223344, WORD); at_neg();
        check("fwd_empty_hit", fwd_hit, 1'b0);
        check("fwd_empty_conflict", fwd_conflict, 1'b0);
        tick(); put_store(32'h201, 32'hFFFFFFAB, BYTE);
        tick(); no_store(); at_neg();
        check("fwd_word_conflict", fwd_conflict, 1'b1);
        check("fwd_word_hit", fwd_hit, 1'b0);
        #1; ld_addr = 32'h201; ld_size = BYTE; #1;
        check("fwd_byte_hit", fwd_hit, 1'b1);
        check("fwd_byte_conflict", fwd_conflict, 1'b0);
        check("fwd_byte_data", fwd_data, 32'hAB);
        ld_addr = 32'h203; #1;
        check("fwd_older_conflict", fwd_conflict, 1'b1);
        tick(); load_req = 1'b0; resp = 4'h1;
        repeat (4) tick();
        at_neg();
        check("fwd_drained", drained, 1'b1);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_retire_buffer.md
Name: store_retire_buffer

Overview:
- Post-commit store queue that sits directly downstream of the retire stage.
- Captures each retired store (command, size, address, data) in one cycle and drains it to the data-memory port in program order.
- Load traffic gets priority on the port.
- Backpressures retire when full and reports when it is drained, so halt is only signalled once every committed store has reached memory.

Parameters:
SB_DEPTH, 4, number of store entries (power of two, >=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
ret_command  in  2  BUS_STORE marks a valid retired store, else BUS_NONE
ret_size  in  MEM_SIZE  store size from retire
ret_addr  in  XLEN  store byte address
ret_data  in  XLEN  store data (rs2 value)
halt  in  1  retire has seen the halting instruction; stores take priority
load_req  in  1  load unit requests the Dmem port this cycle
Dmem2proc_response  in  4  nonzero = request accepted this cycle
proc2Dmem_command  out  2  BUS_STORE or BUS_NONE
proc2Dmem_size  out  MEM_SIZE  head entry size
proc2Dmem_addr  out  XLEN  head entry address
proc2Dmem_data  out  XLEN  head entry data
sb_full  out  1  registered: count==SB_DEPTH; retire must stall
sb_empty  out  1  registered: count==0
drained  out  1  sb_empty && state==SB_IDLE
overflow  out  1  sticky error: store presented while full

Behaviour:
- Storage: circular FIFO with head/tail pointers of $clog2(SB_DEPTH) bits wrapping modulo SB_DEPTH; count is $clog2(SB_DEPTH+1) bits.
- Enqueue: ret_command==BUS_STORE && !sb_full writes the entry at tail in that cycle. It is visible at the head no earlier than the next cycle.
- Store presented while sb_full: the entry is dropped, overflow is set and stays set until reset, and pointers are unchanged.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. sb_full is based on the registered count, so a pop in the same cycle does not admit a store into a full buffer.
- FSM states are SB_IDLE and SB_REQ.
  - SB_IDLE -> SB_REQ when count>0 && (!load_req || halt).
  - SB_REQ drives the head entry. If Dmem2proc_response!=0, the head is popped. The FSM stays in SB_REQ if entries remain (back-to-back issue), otherwise it returns to SB_IDLE.
  - SB_REQ with load_req && !halt: the command is BUS_NONE that cycle, the response is ignored, and the FSM returns to SB_IDLE (load preempts).
  - SB_REQ with response==0: retry with the same entry the next cycle.
- proc2Dmem_command = BUS_STORE only when state==SB_REQ && (!load_req || halt). Otherwise it is BUS_NONE, and size/addr/data still show the head entry (don't-care).
- Stores are issued strictly in retire order. An entry is never reissued after acceptance.
- Reset: state SB_IDLE, head=tail=count=0, proc2Dmem_command=BUS_NONE, sb_full=0, sb_empty=1, drained=1, overflow=0. Reset mid-request discards all entries with no further command.
- Halt does not flush the buffer. drained rises the cycle after the final accepted pop.

Optional Feature:
- Macro: SB_LOAD_FWD_EN.
- When defined, adds these ports:
  - ld_addr in XLEN
  - ld_size in MEM_SIZE
  - fwd_hit out 1
  - fwd_conflict out 1
  - fwd_data out XLEN
- Forwarding logic is combinational over valid entries, youngest first.
  - Exact address and size match on the youngest overlapping entry: fwd_hit=1 and fwd_data is that entry's data, zero-extended to size.
  - Any byte overlap that is not an exact match: fwd_conflict=1, and the load must retry.
  - Both outputs are 0 when the buffer is empty.
- When undefined, these ports do not exist and the load unit must wait for sb_empty before issuing.

Decomposition:
- SB_ENTRY struct {addr, data, size} and SB_STATE enum {SB_IDLE, SB_REQ} go in sys_defs.svh alongside the existing bus types.
- An optional sub-module, sb_fwd_lookup (forwarding search), is instantiated only under SB_LOAD_FWD_EN. Everything else stays inline.

Test Plan:
- Single store: retire SW addr 0x100 data 0xDEADBEEF, response=1 -> BUS_STORE/0x100/0xDEADBEEF one cycle after enqueue; empty and drained the next cycle.
- Fill: 4 back-to-back stores with response=0 -> sb_full=1 after the 4th. A 5th store sets overflow=1 and is not issued. Then response=1 -> 4 stores leave in order on consecutive cycles.
- Load priority: 2 entries queued, load_req=1 for 3 cycles -> command=BUS_NONE for those cycles. Store issue resumes the cycle after load_req falls.
- Halt: 2 entries, load_req=1 held, halt=1 -> stores issue regardless of load_req; drained rises after the 2nd accepted pop.
- Wrap and simultaneous events: 10 stores with enqueue and pop in the same cycles -> count stays constant, pointers wrap, and the data order is preserved.
- SB_LOAD_FWD_EN: queue SW 0x200=0x11223344 and SB 0x201.
  - Load word 0x200 -> fwd_conflict=1.
  - Load byte 0x201 -> fwd_hit=1 with the byte's data.
